// File: rtl/score_collector.sv
// Packs a stream of W-bit output-layer scores into an N_CLASS*W vector with valid/ready on both sides.
// Define SCORE_COLLECTOR_ARGMAX_EN to track a running one-hot argmax (maxi); otherwise maxi is tied to 0.
module score_collector #(
    parameter int N_CLASS = 10,
    parameter int W       = 8,
    localparam int IDX_W  = $clog2(N_CLASS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CLASS*W-1:0]   ans,
    output logic [IDX_W-1:0]       idx,
    output logic [N_CLASS-1:0]     maxi
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             accept;
    logic             last;

    // flush drops any same-cycle beat, so it never reaches the slot write
    assign accept    = in_valid && (state == FILL) && !flush;
    assign last      = (idx == IDX_W'(N_CLASS - 1));
    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (flush) begin
            state_nxt = FILL;
            idx_nxt   = '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        if (last) begin
                            state_nxt = HOLD;
                            idx_nxt   = IDX_W'(N_CLASS);
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = FILL;
                        idx_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Only the addressed slot is written; the rest keep the previous vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ans <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_CLASS; i++) begin
                if (idx == IDX_W'(i)) begin
                    ans[i*W +: W] <= in_data;
                end
            end
        end
    end

`ifdef SCORE_COLLECTOR_ARGMAX_EN
    logic [W-1:0]       best_val;
    logic [N_CLASS-1:0] maxi_q;
    logic [N_CLASS-1:0] idx_onehot;

    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (idx == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    // Strictly-greater update keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_val <= '0;
            maxi_q   <= '0;
        end else if (flush) begin
            best_val <= '0;
            maxi_q   <= '0;
        end else if (accept) begin
            if ((idx == '0) || (in_data > best_val)) begin
                best_val <= in_data;
                maxi_q   <= idx_onehot;
            end
        end
    end

    assign maxi = maxi_q;
`else
    assign maxi = '0;
`endif

endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector: reset, full/gapped vectors, back-pressure, flush, async reset in HOLD.
module tb_score_collector;

    localparam int N  = 10;
    localparam int W  = 8;
    localparam int IW = $clog2(N + 1);
`ifdef SCORE_COLLECTOR_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  ans;
    logic [IW-1:0]   idx;
    logic [N-1:0]    maxi;

    int n_chk = 0;
    int n_err = 0;

    score_collector #(.N_CLASS(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .idx       (idx),
        .maxi      (maxi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] v [N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
        return r;
    endfunction

    function automatic logic [N-1:0] em(input logic [N-1:0] onehot);
        return ARGMAX ? onehot : '0;
    endfunction

    logic [W-1:0]   v1 [N] = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd200, 8'd0, 8'd5, 8'd5, 8'd8};
    logic [W-1:0]   v2 [N];
    logic [W-1:0]   v3 [N] = '{8'd9, 8'd7, 8'd7, 8'd9, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd9};
    logic [N*W-1:0] exp1, exp2, exp3, ones;
    logic [N*W-1:0] ans_snap;
    int             cyc;

    initial begin
        for (int i = 0; i < N; i++) v2[i] = W'(i * 11 + 16);
        exp1 = pack(v1);
        exp2 = pack(v2);
        exp3 = pack(v3);
        ones = '0;
        for (int i = 0; i < N; i++) ones[i*W +: W] = 8'h01;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_ans", ans, '0);
        chk("rst_ov", out_valid, 0);
        rst = 1'b1;
        step();
        chk("idle_idx", idx, 0);
        chk("idle_ir", in_ready, 1);
        chk("idle_ov", out_valid, 0);
        chk("idle_ans", ans, '0);
        chk("idle_maxi", maxi, '0);

        // back-to-back full vector
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = v1[k];
            step();
            if (k < N - 1) begin
                chk("full_idx", idx, k + 1);
                chk("full_ov_lo", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        chk("full_ov", out_valid, 1);
        chk("full_ir", in_ready, 0);
        chk("full_idx10", idx, N);
        chk("full_ans", ans, exp1);
        chk("full_slot0", ans[7:0], 8'd3);
        chk("full_slot3", ans[31:24], 8'd200);
        chk("full_maxi", maxi, em(10'b0000001000));
        step();
        chk("rel_ir", in_ready, 1);
        chk("rel_ov", out_valid, 0);
        chk("rel_idx", idx, 0);
        chk("rel_ans_kept", ans, exp1);
        chk("rel_maxi_kept", maxi, em(10'b0000001000));

        // back-pressure
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = v2[k];
            step();
        end
        in_data = 8'hAA;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_ir", in_ready, 0);
            chk("bp_ov", out_valid, 1);
            chk("bp_ans", ans, exp2);
        end
        chk("bp_maxi", maxi, em(10'b1000000000));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rel_idx", idx, 0);
        chk("bp_rel_ans", ans, exp2);
        step();
        chk("bp_aa_slot0", ans[7:0], 8'hAA);
        chk("bp_aa_rest", ans[N*W-1:8], exp2[N*W-1:8]);
        chk("bp_aa_idx", idx, 1);
        chk("bp_aa_maxi", maxi, em(10'b0000000001));

        // flush at idx=4 with a coincident beat
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        chk("pre_flush_idx", idx, 4);
        ans_snap = ans;
        flush = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idx", idx, 0);
        chk("flush_ans", ans, ans_snap);
        chk("flush_slot4", ans[39:32], v2[4]);
        chk("flush_ir", in_ready, 1);
        chk("flush_maxi", maxi, '0);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = 8'h01;
            step();
        end
        in_valid = 1'b0;
        chk("refill_ov", out_valid, 1);
        chk("refill_ans", ans, ones);
        chk("refill_maxi", maxi, em(10'b0000000001));
        out_ready = 1'b1;
        step();
        chk("refill_rel", in_ready, 1);

        // gapped input
        cyc = 0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = v1[k];
            step(); cyc++;
            in_valid = 1'b0;
            if (k < N - 1) begin
                chk("gap_ov_lo", out_valid, 0);
                step(); cyc++;
            end
        end
        chk("gap_ov", out_valid, 1);
        chk("gap_cycles", cyc, 19);
        chk("gap_ans", ans, exp1);
        chk("gap_maxi", maxi, em(10'b0000001000));
        step();
        chk("gap_rel", in_ready, 1);

        // async reset while holding
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = v1[k];
            step();
        end
        in_valid = 1'b0;
        chk("ar_hold_ov", out_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_ans", ans, '0);
        chk("ar_maxi", maxi, '0);
        chk("ar_idx", idx, 0);
        chk("ar_ir", in_ready, 1);
        step();
        rst = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = v3[k];
            step();
        end
        in_valid = 1'b0;
        chk("post_ov", out_valid, 1);
        chk("post_ans", ans, exp3);
        chk("post_maxi_tie", maxi, em(10'b0000000001));
        out_ready = 1'b1;
        step();
        chk("post_rel", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
